// File: rtl/ram_program_loader.sv
// ---------------------------------------------------------------------------
// ram_program_loader
//
// Purpose
//   Fills the 16-byte program RAM from ui_in while the CPU is held in
//   programming mode. The loader and the host use a ready/strobe handshake:
//     - the loader raises ready;
//     - the host puts a byte on ui_in and pulses host_valid.
//   For each byte the loader runs three one-cycle bus steps:
//     1. load the MAR address;
//     2. load the MAR data;
//     3. strobe the RAM write.
//   The CPU control block stays stalled until the loader returns to IDLE.
//
// Parameters
//   ADDR_W  RAM address width (<= 8, the address is zero-extended onto the bus)
//   WORDS   number of bytes to load; the last address is WORDS-1
//           (WORDS <= 2**ADDR_W)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous reset, active-low
//   programming  programming-mode request (uio_in[0])
//   host_valid   host byte strobe; ui_in is stable while it is high
//   ui_in        host byte (only present with LOADER_CHECKSUM_EN)
//   ready        loader is waiting for the next byte
//   done_load    all WORDS bytes have been written
//   cpu_hold     stalls the CPU control block; high in every state but IDLE
//   checksum     running mod-256 sum of the loaded bytes
//                (only present with LOADER_CHECKSUM_EN)
//   addr_bus     {0, addr}; only meaningful while addr_bus_en is high
//   addr_bus_en  loader owns the shared bus with the address
//   read_ui_in   ui_in is gated onto the shared bus
//   n_load_addr  MAR address load, active-low
//   n_load_data  MAR data load, active-low
//   n_load_ram   RAM write strobe, active-low
//
// Optional feature
//   LOADER_CHECKSUM_EN - when defined, adds the ui_in input, the checksum
//   output and the checksum register. Nothing else changes.
// ---------------------------------------------------------------------------
module ram_program_loader #(
    parameter int ADDR_W = 4,
    parameter int WORDS  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       programming,
    input  logic       host_valid,
`ifdef LOADER_CHECKSUM_EN
    input  logic [7:0] ui_in,
`endif
    output logic       ready,
    output logic       done_load,
    output logic       cpu_hold,
`ifdef LOADER_CHECKSUM_EN
    output logic [7:0] checksum,
`endif
    output logic [7:0] addr_bus,
    output logic       addr_bus_en,
    output logic       read_ui_in,
    output logic       n_load_addr,
    output logic       n_load_data,
    output logic       n_load_ram
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        ADDR,
        DATA,
        WRITE,
        WAIT_RELEASE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // A byte that has entered ADDR always finishes its write before
    // programming is looked at again. Inside the waiting states, an abort
    // (programming low) wins over the host strobe.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (programming) begin
                    state_next = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (!programming) begin
                    state_next = IDLE;
                end else if (host_valid) begin
                    state_next = ADDR;
                end
            end
            ADDR: begin
                state_next = DATA;
            end
            DATA: begin
                state_next = WRITE;
            end
            WRITE: begin
                if (addr == LAST_ADDR) begin
                    state_next = DONE;
                end else begin
                    state_next = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                // A held strobe parks here, so it loads exactly one byte.
                if (!programming) begin
                    state_next = IDLE;
                end else if (!host_valid) begin
                    state_next = WAIT_BYTE;
                end
            end
            DONE: begin
                if (!programming) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Load address.
    // The address restarts at 0 whenever a new programming session starts.
    // It then advances after every write except the last one, so it never
    // wraps. An abort leaves it alone until the next session clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (state == IDLE && programming) begin
            addr <= '0;
        end else if (state == WRITE && addr != LAST_ADDR) begin
            addr <= addr + 1'b1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running checksum.
    // The byte is summed while it is on the bus in DATA, which is the same
    // cycle in which the MAR captures it. The sum is cleared at the start of
    // each programming session.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= 8'd0;
        end else if (state == IDLE && programming) begin
            checksum <= 8'd0;
        end else if (state == DATA) begin
            checksum <= checksum + ui_in;
        end
    end
`endif

    // Moore output decode.
    // Each bus step owns the shared bus for exactly one state. Because of
    // this, addr_bus_en and read_ui_in can never be high together.
    always_comb begin
        ready       = 1'b0;
        done_load   = 1'b0;
        cpu_hold    = 1'b1;
        addr_bus_en = 1'b0;
        read_ui_in  = 1'b0;
        n_load_addr = 1'b1;
        n_load_data = 1'b1;
        n_load_ram  = 1'b1;
        addr_bus    = 8'd0;
        addr_bus[ADDR_W-1:0] = addr;
        unique case (state)
            IDLE: begin
                cpu_hold = 1'b0;
            end
            WAIT_BYTE: begin
                ready = 1'b1;
            end
            ADDR: begin
                addr_bus_en = 1'b1;
                n_load_addr = 1'b0;
            end
            DATA: begin
                read_ui_in  = 1'b1;
                n_load_data = 1'b0;
            end
            WRITE: begin
                n_load_ram = 1'b0;
            end
            WAIT_RELEASE: begin
            end
            DONE: begin
                done_load = 1'b1;
            end
            default: begin
                cpu_hold = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_program_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_program_loader
//
// Purpose
//   Directed bench for ram_program_loader. It models the external MAR and the
//   RAM from the loader's strobes, so writes and addresses are checked
//   against hand-computed values.
//
// Optional feature
//   Compile with LOADER_CHECKSUM_EN to also connect ui_in and checksum and to
//   check the checksum values.
// ---------------------------------------------------------------------------
module tb_ram_program_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       programming;
    logic       host_valid;
    logic [7:0] ui_in;
    logic       ready;
    logic       done_load;
    logic       cpu_hold;
    logic [7:0] checksum;
    logic [7:0] addr_bus;
    logic       addr_bus_en;
    logic       read_ui_in;
    logic       n_load_addr;
    logic       n_load_data;
    logic       n_load_ram;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram_model [16];
    logic [3:0] mar_model;
    logic [7:0] mdr_model;
    int         write_count = 0;
    logic       mon_en = 1'b0;

    always #5 clk = ~clk;

`ifndef LOADER_CHECKSUM_EN
    assign checksum = 8'd0;
`endif

    ram_program_loader #(.ADDR_W(4), .WORDS(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .programming (programming),
        .host_valid  (host_valid),
`ifdef LOADER_CHECKSUM_EN
        .ui_in       (ui_in),
`endif
        .ready       (ready),
        .done_load   (done_load),
        .cpu_hold    (cpu_hold),
`ifdef LOADER_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .addr_bus    (addr_bus),
        .addr_bus_en (addr_bus_en),
        .read_ui_in  (read_ui_in),
        .n_load_addr (n_load_addr),
        .n_load_data (n_load_data),
        .n_load_ram  (n_load_ram)
    );

    // External MAR/RAM model.
    // Strobes are sampled mid-cycle, away from the DUT's clock edge. The bus
    // exclusivity check runs here every cycle once reset has been applied.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ((addr_bus_en & read_ui_in) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bus_exclusive got en=%b rd=%b required not both high",
                         addr_bus_en, read_ui_in);
            end
            if (n_load_addr === 1'b0) mar_model = addr_bus[3:0];
            if (n_load_data === 1'b0 && read_ui_in === 1'b1) mdr_model = ui_in;
            if (n_load_ram === 1'b0) begin
                ram_model[mar_model] = mdr_model;
                write_count++;
            end
        end
    end

    // Advance to just after the next falling edge. Driving and sampling
    // happen here, well clear of the rising edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout got ready=%b required 1", ready);
        end
    endtask

    // Sends one byte with a one-cycle strobe.
    // Records what the DUT shows in the ADDR, DATA and WRITE cycles, then
    // steps once more past the write.
    task automatic applyStimulus(input logic [7:0] b,
                                 output logic [7:0] seen_addr,
                                 output logic seen_en,
                                 output logic seen_rd,
                                 output logic seen_wr_n);
        wait_ready();
        ui_in      = b;
        host_valid = 1'b1;
        step();
        host_valid = 1'b0;
        seen_addr  = addr_bus;
        seen_en    = addr_bus_en;
        step();
        seen_rd    = read_ui_in;
        step();
        seen_wr_n  = n_load_ram;
        step();
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        programming = 1'b0;
        host_valid  = 1'b0;
        ui_in       = 8'h00;
        step();
        mon_en = 1'b1;
        checks++;
        if ({ready, done_load, cpu_hold, addr_bus_en, read_ui_in} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_flags got rdy/done/hold/en/rd=%b required 00000",
                     {ready, done_load, cpu_hold, addr_bus_en, read_ui_in});
        end
        checks++;
        if ({n_load_addr, n_load_data, n_load_ram} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL reset_strobes got %b required 111",
                     {n_load_addr, n_load_data, n_load_ram});
        end
        checks++;
        if (addr_bus !== 8'h00 || checksum !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_addr_sum got addr=%h sum=%h required 00 00",
                     addr_bus, checksum);
        end
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (cpu_hold !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_no_prog got hold=%b ready=%b required 0 0",
                     cpu_hold, ready);
        end
    endtask

    task automatic test_full_load();
        logic [7:0] sa;
        logic       se, sr, sw;
        for (int i = 0; i < 16; i++) ram_model[i] = 8'hEE;
        write_count = 0;
        programming = 1'b1;
        step();
        step();
        checks++;
        if (ready !== 1'b1 || cpu_hold !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait_byte_entry got ready=%b hold=%b required 1 1",
                     ready, cpu_hold);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i), sa, se, sr, sw);
            checks++;
            if (se !== 1'b1 || sa !== 8'(i)) begin
                errors++;
                $display("[TB] FAIL addr_phase byte %0d got en=%b bus=%h required 1 %h",
                         i, se, sa, 8'(i));
            end
            checks++;
            if (sr !== 1'b1 || sw !== 1'b0) begin
                errors++;
                $display("[TB] FAIL data_write_phase byte %0d got rd=%b wr_n=%b required 1 0",
                         i, sr, sw);
            end
        end
        checks++;
        if (done_load !== 1'b1 || ready !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_state got done=%b ready=%b hold=%b required 1 0 1",
                     done_load, ready, cpu_hold);
        end
        checks++;
        if (write_count !== 16) begin
            errors++;
            $display("[TB] FAIL write_count got %0d required 16", write_count);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (ram_model[i] !== 8'(i)) begin
                errors++;
                $display("[TB] FAIL ram_content addr %0d got %h required %h",
                         i, ram_model[i], 8'(i));
            end
        end
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 8'h78) begin
            errors++;
            $display("[TB] FAIL checksum_full got %h required 78", checksum);
        end
`endif
        step();
        step();
        checks++;
        if (done_load !== 1'b1 || write_count !== 16) begin
            errors++;
            $display("[TB] FAIL done_hold got done=%b writes=%0d required 1 16",
                     done_load, write_count);
        end
        programming = 1'b0;
        step();
        checks++;
        if (done_load !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_release got done=%b hold=%b required 0 0",
                     done_load, cpu_hold);
        end
    endtask

    task automatic test_held_strobe();
        logic [7:0] sa;
        logic       se, sr, sw;
        int         w0;
        programming = 1'b1;
        step();
        wait_ready();
        w0         = write_count;
        ui_in      = 8'hA5;
        host_valid = 1'b1;
        for (int c = 0; c < 10; c++) step();
        checks++;
        if (ready !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("[TB] FAIL held_parked got ready=%b hold=%b required 0 1",
                     ready, cpu_hold);
        end
        host_valid = 1'b0;
        step();
        checks++;
        if (write_count - w0 !== 1 || ram_model[0] !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL held_one_write got writes=%0d ram0=%h required 1 a5",
                     write_count - w0, ram_model[0]);
        end
        applyStimulus(8'h5A, sa, se, sr, sw);
        checks++;
        if (sa !== 8'h01 || ram_model[1] !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL held_next_addr got bus=%h ram1=%h required 01 5a",
                     sa, ram_model[1]);
        end
        programming = 1'b0;
        step();
        step();
    endtask

    task automatic test_abort();
        logic [7:0] sa;
        logic       se, sr, sw;
        programming = 1'b1;
        step();
        for (int i = 0; i < 5; i++) applyStimulus(8'h10 + 8'(i), sa, se, sr, sw);
        wait_ready();
        programming = 1'b0;
        step();
        checks++;
        if (cpu_hold !== 1'b0 || done_load !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle got hold=%b done=%b ready=%b required 0 0 0",
                     cpu_hold, done_load, ready);
        end
        programming = 1'b1;
        step();
        applyStimulus(8'h55, sa, se, sr, sw);
        checks++;
        if (sa !== 8'h00 || ram_model[0] !== 8'h55 || ram_model[1] !== 8'h11) begin
            errors++;
            $display("[TB] FAIL abort_reload got bus=%h ram0=%h ram1=%h required 00 55 11",
                     sa, ram_model[0], ram_model[1]);
        end
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 8'h55) begin
            errors++;
            $display("[TB] FAIL checksum_reload got %h required 55", checksum);
        end
`endif
        programming = 1'b0;
        step();
        step();
    endtask

    task automatic test_late_abort();
        int w0;
        programming = 1'b1;
        step();
        wait_ready();
        w0         = write_count;
        ui_in      = 8'h3C;
        host_valid = 1'b1;
        step();
        host_valid = 1'b0;
        step();
        checks++;
        if (read_ui_in !== 1'b1) begin
            errors++;
            $display("[TB] FAIL late_data got rd=%b required 1", read_ui_in);
        end
        programming = 1'b0;
        step();
        checks++;
        if (n_load_ram !== 1'b0 || cpu_hold !== 1'b1) begin
            errors++;
            $display("[TB] FAIL late_write got wr_n=%b hold=%b required 0 1",
                     n_load_ram, cpu_hold);
        end
        step();
        checks++;
        if (cpu_hold !== 1'b1 || ready !== 1'b0 || n_load_ram !== 1'b1) begin
            errors++;
            $display("[TB] FAIL late_release got hold=%b ready=%b wr_n=%b required 1 0 1",
                     cpu_hold, ready, n_load_ram);
        end
        step();
        checks++;
        if (cpu_hold !== 1'b0 || write_count - w0 !== 1 || ram_model[0] !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL late_idle got hold=%b writes=%0d ram0=%h required 0 1 3c",
                     cpu_hold, write_count - w0, ram_model[0]);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        programming = 1'b1;
        step();
        wait_ready();
        w0         = write_count;
        ui_in      = 8'h99;
        host_valid = 1'b1;
        step();
        host_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if ({n_load_addr, n_load_data, n_load_ram} !== 3'b111 || cpu_hold !== 1'b0 ||
            addr_bus_en !== 1'b0 || read_ui_in !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid got strobes=%b hold=%b en=%b rd=%b required 111 0 0 0",
                     {n_load_addr, n_load_data, n_load_ram}, cpu_hold, addr_bus_en, read_ui_in);
        end
        rst_n       = 1'b1;
        programming = 1'b0;
        step();
        checks++;
        if (write_count !== w0) begin
            errors++;
            $display("[TB] FAIL reset_mid_nowrite got writes=%0d required %0d",
                     write_count, w0);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_held_strobe();
        test_abort();
        test_late_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Last-resort stop in case something stalls the sequence.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
